// File: rtl/mem_if_rr.sv
// mem_if_rr: round-robin multi-client byte-lane memory interface with split word access; optional MEM_IF_MISALIGN_TRAP_EN traps misaligned accesses
module mem_if_rr #(
  parameter int M_WIDTH = 32,
  parameter int CLIENT_CNT = 2,
  parameter int RD_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CLIENT_CNT-1:0]          client_requests,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]  client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]          client_wes,
  input  logic [2*CLIENT_CNT-1:0]        client_data_widths_packed,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]  client_data_outs_packed,
  output logic [CLIENT_CNT*M_WIDTH-1:0]  client_data_ins_packed,
  output logic [CLIENT_CNT-1:0]          client_readies,
  output logic [CLIENT_CNT-1:0]          client_errors,
  output logic [M_WIDTH-$clog2(M_WIDTH/8)-1:0] mem_addr,
  output logic [M_WIDTH-1:0]             mem_data_out,
  output logic [M_WIDTH/8-1:0]           mem_we_outs,
  input  logic [M_WIDTH-1:0]             mem_data_in
);
  localparam int M_BYTES = M_WIDTH / 8;
  localparam int BSW = $clog2(M_BYTES);
  localparam int AW = M_WIDTH - BSW;
  localparam int PW = CLIENT_CNT > 1 ? $clog2(CLIENT_CNT) : 1;
  localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t                 state;
  logic [PW-1:0]          ptr, idx, gnt;
  logic                   any;
  int                     s;
  logic [CLIENT_CNT-1:0]  rot;
  logic [M_WIDTH-1:0]     addr, acc, dmask, hi_do;
  logic [M_BYTES-1:0]     hi_we;
  logic                   we, err, split;
  logic [CW-1:0]          cnt;
  logic                   last;
  logic [BSW-1:0]         off;
  logic [BSW:0]           hs;

  logic [M_WIDTH-1:0]     g_addr, g_dat, g_dm;
  logic                   g_we, g_split, g_err;
  logic [1:0]             g_code;
  logic [3:0]             g_nb;
  logic [BSW-1:0]         g_off;
  logic [M_BYTES-1:0]     g_bm;
  logic [2*M_BYTES-1:0]   g_wm;
  logic [2*M_WIDTH-1:0]   g_dw;

  assign rot = CLIENT_CNT'({client_requests, client_requests} >> ptr);

  // first requester at or after the pointer, wrapping
  always_comb begin
    gnt = '0;
    any = 1'b0;
    s = 0;
    for (int k = CLIENT_CNT - 1; k >= 0; k--)
      if (rot[k]) begin
        s = int'(ptr) + k;
        gnt = PW'(s >= CLIENT_CNT ? s - CLIENT_CNT : s);
        any = 1'b1;
      end
  end

  assign g_addr  = client_addrs_packed[int'(gnt)*M_WIDTH +: M_WIDTH];
  assign g_dat   = client_data_outs_packed[int'(gnt)*M_WIDTH +: M_WIDTH];
  assign g_we    = client_wes[gnt];
  assign g_code  = client_data_widths_packed[int'(gnt)*2 +: 2];
  assign g_nb    = 4'd1 << g_code;
  assign g_off   = g_addr[BSW-1:0];
  assign g_bm    = (M_BYTES'(1) << g_nb) - M_BYTES'(1);
  assign g_split = int'(g_off) + int'(g_nb) > M_BYTES;
  assign g_wm    = {{M_BYTES{1'b0}}, g_bm} << g_off;
  assign g_dw    = {{M_WIDTH{1'b0}}, g_dat} << {g_off, 3'b000};
`ifdef MEM_IF_MISALIGN_TRAP_EN
  assign g_err   = (int'(g_nb) > M_BYTES) || ((g_off & BSW'(g_nb - 4'd1)) != '0);
`else
  assign g_err   = int'(g_nb) > M_BYTES;
`endif

  for (genvar b = 0; b < M_BYTES; b++) begin : g_mask
    assign g_dm[8*b +: 8] = {8{g_bm[b]}};
  end

  assign off  = addr[BSW-1:0];
  assign hs   = (BSW+1)'(M_BYTES) - {1'b0, off};
  assign last = int'(cnt) == RD_LAT - 1;

  // arbitration, phase sequencing and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      addr <= '0;
      we <= 1'b0;
      err <= 1'b0;
      split <= 1'b0;
      dmask <= '0;
      hi_we <= '0;
      hi_do <= '0;
      acc <= '0;
      cnt <= '0;
      mem_addr <= '0;
      mem_data_out <= '0;
      mem_we_outs <= '0;
      client_readies <= '0;
      client_errors <= '0;
      client_data_ins_packed <= '0;
    end else begin
      case (state)
        IDLE:
          if (any) begin
            idx <= gnt;
            ptr <= (int'(gnt) == CLIENT_CNT - 1) ? '0 : gnt + PW'(1);
            addr <= g_addr;
            we <= g_we;
            err <= g_err;
            split <= g_split;
            dmask <= g_dm;
            hi_we <= g_we ? g_wm[2*M_BYTES-1:M_BYTES] : '0;
            hi_do <= g_dw[2*M_WIDTH-1:M_WIDTH];
            acc <= '0;
            cnt <= '0;
            if (g_err) state <= DONE;
            else begin
              state <= ACC_LO;
              mem_addr <= g_addr[M_WIDTH-1:BSW];
              mem_data_out <= g_dw[M_WIDTH-1:0];
              mem_we_outs <= g_we ? g_wm[M_BYTES-1:0] : '0;
            end
          end
        ACC_LO: begin
          mem_we_outs <= '0;
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
            acc <= mem_data_in >> {off, 3'b000};
            if (split) begin
              state <= ACC_HI;
              mem_addr <= addr[M_WIDTH-1:BSW] + AW'(1);
              mem_data_out <= hi_do;
              mem_we_outs <= hi_we;
            end else state <= DONE;
          end
        end
        ACC_HI: begin
          mem_we_outs <= '0;
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt <= '0;
            acc <= acc | (mem_data_in << {hs, 3'b000});
            state <= DONE;
          end
        end
        DONE:
          if (!client_requests[idx]) begin
            state <= IDLE;
            client_readies <= '0;
            client_errors <= '0;
            client_data_ins_packed <= '0;
          end else begin
            client_readies[idx] <= 1'b1;
            client_errors[idx] <= err;
            client_data_ins_packed[int'(idx)*M_WIDTH +: M_WIDTH] <= we ? '0 : acc & dmask;
          end
      endcase
    end
endmodule

// File: tb/tb_mem_if_rr.sv
// tb_mem_if_rr: randomized and directed checks of mem_if_rr against a byte-addressed memory model
module tb_mem_if_rr;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic rq0 = 1'b0, rq1 = 1'b0;
  logic [31:0] ca[2], cd[2];
  logic cw[2];
  logic [1:0] cc[2];
  logic [1:0] client_requests, client_wes, client_readies, client_errors;
  logic [3:0] client_data_widths_packed, mem_we_outs;
  logic [63:0] client_addrs_packed, client_data_outs_packed, client_data_ins_packed;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_out, mem_data_in;

  assign client_requests = {rq1, rq0};
  assign client_addrs_packed = {ca[1], ca[0]};
  assign client_wes = {cw[1], cw[0]};
  assign client_data_widths_packed = {cc[1], cc[0]};
  assign client_data_outs_packed = {cd[1], cd[0]};

  mem_if_rr dut (
    .clk(clk), .rst(rst),
    .client_requests(client_requests),
    .client_addrs_packed(client_addrs_packed),
    .client_wes(client_wes),
    .client_data_widths_packed(client_data_widths_packed),
    .client_data_outs_packed(client_data_outs_packed),
    .client_data_ins_packed(client_data_ins_packed),
    .client_readies(client_readies),
    .client_errors(client_errors),
    .mem_addr(mem_addr),
    .mem_data_out(mem_data_out),
    .mem_we_outs(mem_we_outs),
    .mem_data_in(mem_data_in)
  );

  logic [31:0] ram[64];
  logic [7:0] shadow[256];
  assign mem_data_in = ram[mem_addr[5:0]];
  always @(posedge clk)
    for (int b = 0; b < 4; b++) if (mem_we_outs[b]) ram[mem_addr[5:0]][8*b +: 8] = mem_data_out[8*b +: 8];

  int n_chk = 0, n_fail = 0, nwe;
  logic [29:0] log_addr[20];
  logic [3:0] log_we[20];
  logic [31:0] log_do[20];
  int order[$];

  function automatic logic [31:0] m_rd(input logic [31:0] a, input int nb);
    logic [31:0] r = 0;
    for (int i = 0; i < nb; i++) r |= 32'(shadow[(int'(a[7:0]) + i) & 255]) << (8*i);
    return r;
  endfunction

  task automatic m_wr(input logic [31:0] a, input int nb, input logic [31:0] d);
    for (int i = 0; i < nb; i++) shadow[(int'(a[7:0]) + i) & 255] = d[8*i +: 8];
  endtask

  task automatic fill_mem();
    for (int w = 0; w < 64; w++) begin
      ram[w] = $urandom;
      for (int b = 0; b < 4; b++) shadow[4*w+b] = ram[w][8*b +: 8];
    end
  endtask

  task automatic set_req(input int c, input logic v);
    if (c == 0) rq0 = v; else rq1 = v;
  endtask

  task automatic run(input int c, input logic [31:0] a, input logic w, input logic [1:0] code,
                     input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat,
                     output logic [63:0] dall);
    ca[c] = a; cw[c] = w; cc[c] = code; cd[c] = d;
    set_req(c, 1'b1);
    nwe = 0; lat = -1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      log_addr[n] = mem_addr; log_we[n] = mem_we_outs; log_do[n] = mem_data_out;
      if (mem_we_outs != 0) nwe++;
      if (client_readies[c]) begin lat = n; break; end
    end
    rd = client_data_ins_packed[c*32 +: 32];
    er = client_errors[c];
    dall = client_data_ins_packed;
    set_req(c, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({client_data_ins_packed, client_readies, client_errors, mem_addr, mem_data_out, mem_we_outs} !== '0) begin n_fail++; $display("FAIL reset_outputs: got nonzero outputs, want all 0"); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({client_readies, mem_we_outs} !== '0) begin n_fail++; $display("FAIL reset_idle: rdy=%b we=%b want 0", client_readies, mem_we_outs); end
  endtask

  task automatic test_aligned_write();
    logic [31:0] rd; logic er; int lat; logic [63:0] dall;
    fill_mem();
    run(0, 32'h10, 1'b1, 2'b10, 32'hDDCCBBAA, rd, er, lat, dall);
    m_wr(32'h10, 4, 32'hDDCCBBAA);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL aw_latency: got %0d want 2", lat); end
    n_chk++; if (log_addr[0] !== 30'd4) begin n_fail++; $display("FAIL aw_addr: got %h want 4", log_addr[0]); end
    n_chk++; if (log_we[0] !== 4'hF) begin n_fail++; $display("FAIL aw_we: got %b want 1111", log_we[0]); end
    n_chk++; if (log_do[0] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL aw_data: got %h want ddccbbaa", log_do[0]); end
    n_chk++; if (nwe !== 1) begin n_fail++; $display("FAIL aw_we_cycles: got %0d want 1", nwe); end
    n_chk++; if ({rd, er} !== 33'd0) begin n_fail++; $display("FAIL aw_result: got data %h err %b want 0 0", rd, er); end
    n_chk++; if (ram[4] !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL aw_mem: got %h want ddccbbaa", ram[4]); end
  endtask

  task automatic test_split_read();
    logic [31:0] rd; logic er; int lat; logic [63:0] dall;
    ram[1] = 32'h44332211; ram[2] = 32'h88776655;
    for (int b = 0; b < 4; b++) begin shadow[4+b] = ram[1][8*b +: 8]; shadow[8+b] = ram[2][8*b +: 8]; end
    run(1, 32'h07, 1'b0, 2'b01, 32'h0, rd, er, lat, dall);
    n_chk++; if (rd !== 32'h00005544) begin n_fail++; $display("FAIL sr_data: got %h want 00005544", rd); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sr_latency: got %0d want 3", lat); end
    n_chk++; if ({log_addr[0], log_addr[1]} !== {30'd1, 30'd2}) begin n_fail++; $display("FAIL sr_addrs: got %h,%h want 1,2", log_addr[0], log_addr[1]); end
    n_chk++; if (dall[31:0] !== 32'h0) begin n_fail++; $display("FAIL sr_other_slice: got %h want 0", dall[31:0]); end
    n_chk++; if (nwe !== 0) begin n_fail++; $display("FAIL sr_no_we: got %0d want 0", nwe); end
  endtask

  task automatic test_split_write();
    logic [31:0] rd; logic er; int lat; logic [63:0] dall;
    run(0, 32'h06, 1'b1, 2'b10, 32'hDDCCBBAA, rd, er, lat, dall);
    m_wr(32'h06, 4, 32'hDDCCBBAA);
    n_chk++; if ({log_addr[0], log_we[0], log_do[0]} !== {30'd1, 4'b1100, 32'hBBAA0000}) begin n_fail++; $display("FAIL sw_lo: got %h %b %h want 1 1100 bbaa0000", log_addr[0], log_we[0], log_do[0]); end
    n_chk++; if ({log_addr[1], log_we[1], log_do[1]} !== {30'd2, 4'b0011, 32'h0000DDCC}) begin n_fail++; $display("FAIL sw_hi: got %h %b %h want 2 0011 0000ddcc", log_addr[1], log_we[1], log_do[1]); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat; logic [63:0] dall;
    run(1, 32'h20, 1'b1, 2'b11, 32'h12345678, rd, er, lat, dall);
    n_chk++; if ({lat, er, nwe, rd} !== {32'd1, 1'b1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL oversize: got lat %0d err %b we_cycles %0d data %h want 1 1 0 0", lat, er, nwe, rd); end
`ifdef MEM_IF_MISALIGN_TRAP_EN
    run(0, 32'h03, 1'b0, 2'b01, 32'h0, rd, er, lat, dall);
    n_chk++; if ({lat, er, nwe} !== {32'd1, 1'b1, 32'd0}) begin n_fail++; $display("FAIL misalign_trap: got lat %0d err %b we_cycles %0d want 1 1 0", lat, er, nwe); end
`endif
  endtask

  task automatic rr_client(input int c);
    logic got;
    for (int k = 0; k < 3; k++) begin
      ca[c] = $urandom_range(0, 63) * 4; cw[c] = 1'b0; cc[c] = 2'b10;
      set_req(c, 1'b1);
      got = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (client_readies[c]) begin got = 1'b1; break; end
      end
      n_chk++; if (!got) begin n_fail++; $display("FAIL rr_timeout: client %0d got no ready want ready", c); end
      order.push_back(c);
      n_chk++; if (client_data_ins_packed[c*32 +: 32] !== m_rd(ca[c], 4)) begin n_fail++; $display("FAIL rr_data: client %0d got %h want %h", c, client_data_ins_packed[c*32 +: 32], m_rd(ca[c], 4)); end
      set_req(c, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    order.delete();
    fork
      rr_client(0);
      rr_client(1);
    join
    n_chk++; if (order.size() !== 6) begin n_fail++; $display("FAIL rr_count: got %0d grants want 6", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      n_chk++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got client %0d want %0d", i, order[i], i % 2); end
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    ca[0] = 32'h06; cw[0] = 1'b1; cc[0] = 2'b10; cd[0] = 32'hCAFEF00D;
    ca[1] = 32'h00; cw[1] = 1'b0; cc[1] = 2'b10;
    rq0 = 1'b1;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    n_chk++; if (mem_addr !== 30'd2) begin n_fail++; $display("FAIL rm_in_hi: got addr %h want 2", mem_addr); end
    rst = 1'b1;
    #1;
    n_chk++; if ({client_data_ins_packed, client_readies, client_errors, mem_addr, mem_data_out, mem_we_outs} !== '0) begin n_fail++; $display("FAIL rm_async_clear: got nonzero outputs want all 0"); end
    rq1 = 1'b1;
    @(negedge clk); @(negedge clk);
    n_chk++; if (client_readies !== 2'b00) begin n_fail++; $display("FAIL rm_no_ready: got %b want 00", client_readies); end
    rst = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (client_readies != 0) begin got = 1'b1; break; end
    end
    n_chk++; if ({got, client_readies} !== 3'b101) begin n_fail++; $display("FAIL rm_next_grant: got ready %b want 01", client_readies); end
    rq0 = 1'b0; rq1 = 1'b0;
    @(negedge clk); @(negedge clk);
    fill_mem();
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, rexp; logic er, w, eexp; int lat, c, nb, lexp, bad; logic [1:0] code; logic [63:0] dall, dexp;
    for (int i = 0; i < 60; i++) begin
      c = $urandom_range(0, 1); a = $urandom; d = $urandom; w = 1'($urandom_range(0, 1)); code = 2'($urandom_range(0, 3));
      nb = 1 << code;
      eexp = nb > 4;
`ifdef MEM_IF_MISALIGN_TRAP_EN
      eexp = eexp || (int'(a[2:0]) % nb != 0);
`endif
      lexp = eexp ? 1 : (int'(a[1:0]) + nb > 4) ? 3 : 2;
      rexp = (eexp || w) ? 32'h0 : m_rd(a, nb);
      dexp = (c == 0) ? {32'h0, rexp} : {rexp, 32'h0};
      run(c, a, w, code, d, rd, er, lat, dall);
      if (!eexp && w) m_wr(a, nb, d);
      n_chk++; if (lat !== lexp) begin n_fail++; $display("FAIL rnd_latency[%0d]: addr %h code %0d got %0d want %0d", i, a, code, lat, lexp); end
      n_chk++; if (er !== eexp) begin n_fail++; $display("FAIL rnd_error[%0d]: addr %h code %0d got %b want %b", i, a, code, er, eexp); end
      n_chk++; if (dall !== dexp) begin n_fail++; $display("FAIL rnd_data[%0d]: addr %h code %0d we %b got %h want %h", i, a, code, w, dall, dexp); end
    end
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (ram[k] !== {shadow[4*k+3], shadow[4*k+2], shadow[4*k+1], shadow[4*k]}) bad++;
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rnd_memory: got %0d differing words want 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin ca[i] = 0; cd[i] = 0; cw[i] = 0; cc[i] = 0; end
    test_reset();
    test_aligned_write();
    test_split_read();
    test_split_write();
    test_error();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_if_rr.md
Name: mem_if_rr

Overview:
- Parametrised successor of the single-port memory interface.
- Arbitrates CLIENT_CNT clients round-robin onto one byte-lane-enabled word memory of M_WIDTH bits.
- Splits accesses that cross a word boundary into two word phases, and supports a configurable synchronous-RAM read latency.
- Sits between the CPU-side clients (fetch, load/store, DMA) and the banked RAM.

Parameters:
- M_WIDTH, 32: memory word and client data width in bits; a power of two, >= 16.
- CLIENT_CNT, 2: number of clients, >= 1.
- RD_LAT, 1: memory read latency in cycles, >= 1.
- Derived: M_BYTES = M_WIDTH/8, BSW = clog2(M_BYTES), AW = M_WIDTH-BSW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- client_requests  in  CLIENT_CNT  per-client request level.
- client_addrs_packed  in  CLIENT_CNT*M_WIDTH  byte addresses.
- client_wes  in  CLIENT_CNT  1 = write.
- client_data_widths_packed  in  2*CLIENT_CNT  width code: 00=8, 01=16, 10=32, 11=64 bits.
- client_data_outs_packed  in  CLIENT_CNT*M_WIDTH  write data, LSB-aligned.
- client_data_ins_packed  out  CLIENT_CNT*M_WIDTH  read data, LSB-aligned, zero-extended.
- client_readies  out  CLIENT_CNT  completion.
- client_errors  out  CLIENT_CNT  error, valid with ready.
- mem_addr  out  AW  word address.
- mem_data_out  out  M_WIDTH  write data.
- mem_we_outs  out  M_BYTES  byte-lane write enables.
- mem_data_in  in  M_WIDTH  read data, valid RD_LAT cycles after mem_addr.

Behaviour:

Reset (asynchronous):
- State goes to IDLE and the round-robin pointer goes to 0.
- All outputs, latched request fields and the data accumulator go to 0.
- An in-flight access is abandoned: no ready, a partial write may have occurred.

States: IDLE, ACC_LO, ACC_HI, DONE.

IDLE (grant):
- Grant the first requesting client at or after the pointer, wrapping.
- Latch idx, addr, we, width code, write data. Set pointer = idx+1 mod CLIENT_CNT.
- Compute off = addr[BSW-1:0], nb = 1<<code, bmask = (1<<nb)-1, split = (off+nb > M_BYTES).
- If nb > M_BYTES: go to DONE with err=1 and no memory access.
- Otherwise go to ACC_LO.

ACC_LO (RD_LAT cycles, counted by a phase counter):
- mem_addr = addr[M_WIDTH-1:BSW]; mem_data_out = data << 8*off.
- mem_we_outs = (bmask << off) truncated to M_BYTES, for writes only, on the first cycle of the phase only; 0 otherwise.
- On the last cycle, acc = mem_data_in >> 8*off.
- Next state: ACC_HI if split, else DONE.

ACC_HI (RD_LAT cycles):
- mem_addr = word+1, wrapping mod 2^AW.
- Let s = M_BYTES-off. mem_data_out = data >> 8*s; mem_we_outs = bmask >> s, first cycle of the phase only.
- On the last cycle, acc |= mem_data_in << 8*s.
- Next state: DONE.

DONE:
- client_readies[idx] = 1 and client_errors[idx] = err.
- Slice idx of client_data_ins_packed = acc masked to nb bytes. Writes return 0.
- Ready holds while client_requests[idx] stays high. Go to IDLE on the cycle it is low (4-phase handshake).
- A client must not change its fields while its request is high.

Idle outputs:
- mem_we_outs = 0 in IDLE/DONE. mem_addr and mem_data_out hold their last values. Non-granted client slices are 0.

Latency (request first high in IDLE at edge 0):
- Aligned: ready at cycle 1+RD_LAT.
- Split: ready at cycle 1+2*RD_LAT.
- Error: ready at cycle 1.

Boundary conditions:
- Simultaneous requests are resolved by the pointer only.
- A client that reasserts in the same cycle it is released is not re-granted ahead of a waiting client.

Optional Feature:
- Macro: MEM_IF_MISALIGN_TRAP_EN.
- Defined: an access with addr not a multiple of nb is not split. It goes IDLE→DONE with err=1 and no memory access.
- Undefined: misaligned accesses are split as above and err is set only for oversize width.

Test Plan (M_WIDTH=32, RD_LAT=1, CLIENT_CNT=2):
- Client 0 aligned 32-bit write, addr 0x10, data 0xDDCCBBAA → one ACC_LO cycle with mem_addr=4, we=1111, data_out=0xDDCCBBAA; ready at cycle 2.
- Client 1 16-bit read at 0x07; word1=0x44332211, word2=0x88776655 → reads word1 then word2; data_in=0x00005544; ready at cycle 3.
- 32-bit write at 0x06, data 0xDDCCBBAA → LO: addr 1, we=1100, data_out=0xBBAA0000; HI: addr 2, we=0011, data_out=0x0000DDCC.
- Both clients request continuously, each dropping request for one cycle after ready → grants alternate 0,1,0,1; none starved.
- rst asserted mid-ACC_HI → all outputs 0 immediately with no clk edge; no ready; next grant goes to client 0.
- Code 11 (64-bit) at M_WIDTH=32 → no we ever; ready+error at cycle 1. With MEM_IF_MISALIGN_TRAP_EN, a 16-bit read at 0x03 → error, no memory access.
